// File: rtl/text_pkg.sv
// Shared types and constants for the text-mode pixel renderer.
// Optional cursor blink is enabled by defining TEXT_BLINK_EN.
package text_pkg;

    localparam int unsigned GLYPH_W        = 8;
    localparam int unsigned GLYPH_H        = 16;
    localparam int unsigned FONT_ADDR_W    = 11;
    localparam int unsigned COORD_W        = 10;
    localparam int unsigned CODE_W         = 16;
    localparam int unsigned GLYPH_CODE_W   = 7;
    localparam int unsigned PAL_ADDR_W     = 4;
    localparam int unsigned COL_W          = 3;
    localparam int unsigned ROW_W          = 4;
    localparam int unsigned DEF_COLOR_BITS = 4;
`ifdef TEXT_BLINK_EN
    localparam int unsigned CUR_X_W        = 7;
    localparam int unsigned CUR_Y_W        = 5;
`endif

    // Cell word layout: [15] invert, [14:8] glyph, [7:4] fg index, [3:0] bg index
    typedef struct packed {
        logic                    inv;
        logic [GLYPH_CODE_W-1:0] glyph;
        logic [PAL_ADDR_W-1:0]   fg;
        logic [PAL_ADDR_W-1:0]   bg;
    } code_t;

    // Palette word at the default channel width, {R,G,B} with R in the MSBs
    typedef struct packed {
        logic [DEF_COLOR_BITS-1:0] r;
        logic [DEF_COLOR_BITS-1:0] g;
        logic [DEF_COLOR_BITS-1:0] b;
    } rgb_t;

    // Per-pixel side-band carried alongside the font lookup
    typedef struct packed {
        logic [COL_W-1:0]      col;
        logic                  inv;
        logic                  hit;
        logic [PAL_ADDR_W-1:0] fg;
        logic [PAL_ADDR_W-1:0] bg;
        logic                  vde;
        logic                  hsync;
        logic                  vsync;
    } side_t;

    // Palette reset fill: entry 0 black, every other entry white
    localparam logic PAL_RST_ENTRY0 = 1'b0;
    localparam logic PAL_RST_OTHERS = 1'b1;

endpackage

// File: rtl/text_pixel_pipe_if.sv
// Video-in / pixel-out bundle of the text pixel pipe.
// Cursor position signals exist only when TEXT_BLINK_EN is defined.
interface text_pixel_pipe_if #(
    parameter int unsigned COLOR_BITS = text_pkg::DEF_COLOR_BITS
);
    logic [text_pkg::COORD_W-1:0]    DrawX;
    logic [text_pkg::COORD_W-1:0]    DrawY;
    logic                            vde_in;
    logic                            hsync_in;
    logic                            vsync_in;
    logic [text_pkg::CODE_W-1:0]     code;
    logic                            pal_we;
    logic [text_pkg::PAL_ADDR_W-1:0] pal_waddr;
    logic [3*COLOR_BITS-1:0]         pal_wdata;
`ifdef TEXT_BLINK_EN
    logic [text_pkg::CUR_X_W-1:0]    cursor_x;
    logic [text_pkg::CUR_Y_W-1:0]    cursor_y;
`endif
    logic [COLOR_BITS-1:0]           Red;
    logic [COLOR_BITS-1:0]           Green;
    logic [COLOR_BITS-1:0]           Blue;
    logic                            vde_out;
    logic                            hsync_out;
    logic                            vsync_out;

    // Timing generator / VRAM side
    modport master (
`ifdef TEXT_BLINK_EN
        output cursor_x, cursor_y,
`endif
        output DrawX, DrawY, vde_in, hsync_in, vsync_in, code,
        output pal_we, pal_waddr, pal_wdata,
        input  Red, Green, Blue, vde_out, hsync_out, vsync_out
    );

    // Renderer side
    modport slave (
`ifdef TEXT_BLINK_EN
        input  cursor_x, cursor_y,
`endif
        input  DrawX, DrawY, vde_in, hsync_in, vsync_in, code,
        input  pal_we, pal_waddr, pal_wdata,
        output Red, Green, Blue, vde_out, hsync_out, vsync_out
    );

endinterface

// File: rtl/font_rom.sv
// Character generator, 16 rows x 8 columns per glyph, MSB is the leftmost pixel.
// Only the populated glyphs are listed; every other code renders blank.
module font_rom
    import text_pkg::*;
(
    input  logic [FONT_ADDR_W-1:0] addr,
    output logic [GLYPH_W-1:0]     data
);

    // Combinational lookup; the pipe registers the result
    always_comb begin
        data = '0;
        case (addr)
            // 0x41 'A'
            11'h412: data = 8'h10;
            11'h413: data = 8'h38;
            11'h414: data = 8'h6c;
            11'h415: data = 8'hc6;
            11'h416: data = 8'hc6;
            11'h417: data = 8'hfe;
            11'h418: data = 8'hc6;
            11'h419: data = 8'hc6;
            11'h41a: data = 8'hc6;
            11'h41b: data = 8'hc6;
            // 0x42 'B'
            11'h422: data = 8'hfc;
            11'h423: data = 8'h66;
            11'h424: data = 8'h66;
            11'h425: data = 8'h66;
            11'h426: data = 8'h7c;
            11'h427: data = 8'h66;
            11'h428: data = 8'h66;
            11'h429: data = 8'h66;
            11'h42a: data = 8'h66;
            11'h42b: data = 8'hfc;
            // 0x48 'H'
            11'h482: data = 8'hc6;
            11'h483: data = 8'hc6;
            11'h484: data = 8'hc6;
            11'h485: data = 8'hc6;
            11'h486: data = 8'hfe;
            11'h487: data = 8'hc6;
            11'h488: data = 8'hc6;
            11'h489: data = 8'hc6;
            11'h48a: data = 8'hc6;
            11'h48b: data = 8'hc6;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/text_palette.sv
// Writable colour palette: one write port, two combinational reads of the stored array.
// A write becomes visible to the read ports on the cycle after its clock edge.
module text_palette
    import text_pkg::*;
#(
    parameter int unsigned COLOR_BITS = DEF_COLOR_BITS,
    parameter int unsigned PAL_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(PAL_DEPTH)-1:0] waddr,
    input  logic [3*COLOR_BITS-1:0]      wdata,
    input  logic [$clog2(PAL_DEPTH)-1:0] fg_idx,
    input  logic [$clog2(PAL_DEPTH)-1:0] bg_idx,
    output logic [3*COLOR_BITS-1:0]      fg_rgb_c,
    output logic [3*COLOR_BITS-1:0]      bg_rgb_c
);

    localparam int unsigned IDX_W  = $clog2(PAL_DEPTH);
    localparam int unsigned WORD_W = 3 * COLOR_BITS;

    logic [WORD_W-1:0] mem [PAL_DEPTH];

    // Entry storage with black/white reset fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PAL_DEPTH); i++) begin
                mem[IDX_W'(i)] <= (i == 0) ? {WORD_W{PAL_RST_ENTRY0}} : {WORD_W{PAL_RST_OTHERS}};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign fg_rgb_c = mem[fg_idx];
    assign bg_rgb_c = mem[bg_idx];

endmodule

// File: rtl/text_pixel_pipe.sv
// Three-stage text-mode pixel renderer: S0 address/side-band, S1 font read, S2 colour.
// Define TEXT_BLINK_EN to add the blinking hardware cursor (cursor ports + blink counter).
module text_pixel_pipe
    import text_pkg::*;
#(
    parameter int unsigned COLOR_BITS   = DEF_COLOR_BITS,
    parameter int unsigned PAL_DEPTH    = 16
`ifdef TEXT_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 30
`endif
) (
    input logic              pixel_clk,
    input logic              reset,
    text_pixel_pipe_if.slave bus
);

    localparam int unsigned IDX_W  = $clog2(PAL_DEPTH);
    localparam int unsigned WORD_W = 3 * COLOR_BITS;

    code_t                  cw_c;
    logic                   cursor_hit_c;
    logic [FONT_ADDR_W-1:0] font_addr_c;
    side_t                  side_c;

    logic [FONT_ADDR_W-1:0] s0_addr;
    side_t                  s0_side;
    logic [GLYPH_W-1:0]     rom_c;
    logic [GLYPH_W-1:0]     s1_rom;
    side_t                  s1_side;

    logic                   pix_bit_c;
    logic                   on_c;
    logic [WORD_W-1:0]      fg_rgb_c;
    logic [WORD_W-1:0]      bg_rgb_c;
    logic [WORD_W-1:0]      colour_c;

    logic [WORD_W-1:0]      rgb_q;
    logic                   vde_q;
    logic                   hsync_q;
    logic                   vsync_q;

    logic                   unused_bits;

    assign cw_c = code_t'(bus.code);

`ifdef TEXT_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic             vsync_prev;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    // Count vsync rising edges; flip the cursor phase every BLINK_FRAMES edges
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            vsync_prev  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vsync_prev <= bus.vsync_in;
            if (bus.vsync_in && !vsync_prev) begin
                if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign cursor_hit_c = blink_phase
                       && (bus.DrawX[COORD_W-1:COL_W] == bus.cursor_x)
                       && (bus.DrawY[ROW_W+CUR_Y_W-1:ROW_W] == bus.cursor_y);
`else
    assign cursor_hit_c = 1'b0;
`endif

    // S0 inputs: font row address and the side-band that travels with it
    always_comb begin
        font_addr_c   = FONT_ADDR_W'(cw_c.glyph) * FONT_ADDR_W'(GLYPH_H)
                      + FONT_ADDR_W'(bus.DrawY[ROW_W-1:0]);
        side_c        = '0;
        side_c.col    = bus.DrawX[COL_W-1:0];
        side_c.inv    = cw_c.inv;
        side_c.hit    = cursor_hit_c;
        side_c.fg     = cw_c.fg;
        side_c.bg     = cw_c.bg;
        side_c.vde    = bus.vde_in;
        side_c.hsync  = bus.hsync_in;
        side_c.vsync  = bus.vsync_in;
    end

    // S0 register
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            s0_addr <= '0;
            s0_side <= '0;
        end else begin
            s0_addr <= font_addr_c;
            s0_side <= side_c;
        end
    end

    font_rom u_font_rom (
        .addr (s0_addr),
        .data (rom_c)
    );

    // S1 register: font row plus side-band in lock-step
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            s1_rom  <= '0;
            s1_side <= '0;
        end else begin
            s1_rom  <= rom_c;
            s1_side <= s0_side;
        end
    end

    text_palette #(
        .COLOR_BITS (COLOR_BITS),
        .PAL_DEPTH  (PAL_DEPTH)
    ) u_palette (
        .clk      (pixel_clk),
        .rst      (reset),
        .we       (bus.pal_we),
        .waddr    (bus.pal_waddr[IDX_W-1:0]),
        .wdata    (bus.pal_wdata),
        .fg_idx   (s1_side.fg[IDX_W-1:0]),
        .bg_idx   (s1_side.bg[IDX_W-1:0]),
        .fg_rgb_c (fg_rgb_c),
        .bg_rgb_c (bg_rgb_c)
    );

    // S2 colour select: column 0 is the glyph MSB, blanked outside active video
    always_comb begin
        pix_bit_c = s1_rom[COL_W'(GLYPH_W - 1) - s1_side.col];
        on_c      = pix_bit_c ^ s1_side.inv ^ s1_side.hit;
        colour_c  = '0;
        if (s1_side.vde) begin
            colour_c = on_c ? fg_rgb_c : bg_rgb_c;
        end
    end

    // S2 output register
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            vde_q   <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            rgb_q   <= colour_c;
            vde_q   <= s1_side.vde;
            hsync_q <= s1_side.hsync;
            vsync_q <= s1_side.vsync;
        end
    end

    assign bus.Red       = rgb_q[WORD_W-1 -: COLOR_BITS];
    assign bus.Green     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
    assign bus.Blue      = rgb_q[COLOR_BITS-1:0];
    assign bus.vde_out   = vde_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;

    // Coordinate and index bits not consumed in every configuration
    assign unused_bits = ^{bus.DrawX, bus.DrawY, bus.pal_waddr, s1_side.fg, s1_side.bg};

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Directed bench for text_pixel_pipe; define TEXT_BLINK_EN to also exercise the cursor.
module tb_text_pixel_pipe;

    logic pixel_clk;
    logic reset;

    int n_checks;
    int n_fail;

    text_pixel_pipe_if #(.COLOR_BITS(4)) bus ();

    text_pixel_pipe #(
        .COLOR_BITS   (4),
        .PAL_DEPTH    (16)
`ifdef TEXT_BLINK_EN
        ,
        .BLINK_FRAMES (2)
`endif
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .bus       (bus.slave)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] code;
        logic [2:0]  sync;
        logic        we;
        logic [3:0]  waddr;
        logic [11:0] wdata;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Row 5 of 'A' is 0xC6; fg=palette[1]=0xFFF, bg=palette[0]=0x000
    localparam logic [11:0] A_ROW [8] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000,
                                          12'h000, 12'hFFF, 12'hFFF, 12'h000};
    localparam logic [11:0] A_INV [8] = '{12'h000, 12'h000, 12'hFFF, 12'hFFF,
                                          12'hFFF, 12'h000, 12'h000, 12'hFFF};
    // {vde, hsync, vsync} patterns and the colour each must produce
    localparam logic [2:0]  SYNC_PAT [8] = '{3'b010, 3'b011, 3'b001, 3'b000,
                                             3'b010, 3'b110, 3'b011, 3'b001};
    localparam logic [11:0] SYNC_RGB [8] = '{12'h000, 12'h000, 12'h000, 12'h000,
                                             12'h000, 12'hFFF, 12'h000, 12'h000};
`ifdef TEXT_BLINK_EN
    // Blink phase after the 1st..6th vsync rising edge with BLINK_FRAMES=2
    localparam logic BLINK_PH [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] obs();
        return {bus.Red, bus.Green, bus.Blue, bus.vde_out, bus.hsync_out, bus.vsync_out};
    endfunction

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [15:0] code,
                         input logic [2:0] sync, input logic we, input logic [3:0] wa,
                         input logic [11:0] wd);
        bus.DrawX     = x;
        bus.DrawY     = y;
        bus.code      = code;
        {bus.vde_in, bus.hsync_in, bus.vsync_in} = sync;
        bus.pal_we    = we;
        bus.pal_waddr = wa;
        bus.pal_wdata = wd;
    endtask

    task automatic add(input logic [9:0] x, input logic [9:0] y, input logic [15:0] code,
                       input logic [2:0] sync, input logic [11:0] rgb,
                       input logic we = 1'b0, input logic [3:0] wa = 4'd0,
                       input logic [11:0] wd = 12'd0);
        vec_t v;
        v.x     = x;
        v.y     = y;
        v.code  = code;
        v.sync  = sync;
        v.we    = we;
        v.waddr = wa;
        v.wdata = wd;
        v.exp   = {rgb, sync};
        tbl.push_back(v);
    endtask

    // One vector per cycle; each vector's output is expected exactly 3 edges later
    task automatic run_table(input string name);
        int n;
        n = tbl.size();
        for (int i = 0; i < n + 3; i++) begin
            @(negedge pixel_clk);
            if (i >= 3) check_eq($sformatf("%s[%0d]", name, i - 3), 32'(obs()), 32'(tbl[i-3].exp));
            if (i < n) drive(tbl[i].x, tbl[i].y, tbl[i].code, tbl[i].sync,
                             tbl[i].we, tbl[i].waddr, tbl[i].wdata);
            else       drive(10'd0, 10'd0, 16'h0000, 3'b000, 1'b0, 4'd0, 12'd0);
        end
        tbl.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
`ifdef TEXT_BLINK_EN
        bus.cursor_x = 7'd3;
        bus.cursor_y = 5'd2;
`endif
        drive(10'd0, 10'd0, 16'h0010, 3'b110, 1'b0, 4'd0, 12'd0);

        // Reset state, then release with a live input
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        check_eq("reset_state", 32'(obs()), 32'h0);
        reset = 1'b0;
        @(negedge pixel_clk);
        check_eq("post_rst_c1", 32'(obs()), 32'h0);
        @(negedge pixel_clk);
        check_eq("post_rst_c2", 32'(obs()), 32'h0);
        @(negedge pixel_clk);
        check_eq("post_rst_c3", 32'(obs()), 32'({12'h000, 3'b110}));

        // Glyph 'A', row 5, columns 0..7
        for (int c = 0; c < 8; c++) add(10'(8 + c), 10'd5, 16'h4110, 3'b100, A_ROW[c]);
        run_table("glyph_a");

        // Same with invert bit
        for (int c = 0; c < 8; c++) add(10'(8 + c), 10'd5, 16'hC110, 3'b100, A_INV[c]);
        run_table("glyph_inv");

        // Blanking and sync pass-through
        for (int k = 0; k < 8; k++) add(10'd8, 10'd5, 16'h4110, SYNC_PAT[k], SYNC_RGB[k]);
        run_table("sync");

        // Palette write landing on the edge that registers the first fg=2 pixel
        add(10'd8,  10'd5, 16'h4120, 3'b100, 12'hFFF);
        add(10'd9,  10'd5, 16'h4120, 3'b100, 12'hF00);
        add(10'd8,  10'd5, 16'h4120, 3'b100, 12'hF00, 1'b1, 4'd2, 12'hF00);
        add(10'd9,  10'd5, 16'h4120, 3'b100, 12'hF00);
        add(10'd10, 10'd5, 16'h4102, 3'b100, 12'hF00);
        add(10'd8,  10'd5, 16'h4102, 3'b100, 12'h000);
        run_table("palette");

        // Reset asserted mid-line clears outputs at once; output resumes 3 edges after release
        drive(10'd8, 10'd5, 16'h4110, 3'b110, 1'b0, 4'd0, 12'd0);
        repeat (4) @(negedge pixel_clk);
        check_eq("pre_reset", 32'(obs()), 32'({12'hFFF, 3'b110}));
        #2 reset = 1'b1;
        #1 check_eq("reset_async", 32'(obs()), 32'h0);
        @(negedge pixel_clk);
        check_eq("reset_hold", 32'(obs()), 32'h0);
        reset = 1'b0;
        @(negedge pixel_clk);
        check_eq("resume_c1", 32'(obs()), 32'h0);
        @(negedge pixel_clk);
        check_eq("resume_c2", 32'(obs()), 32'h0);
        @(negedge pixel_clk);
        check_eq("resume_c3", 32'(obs()), 32'({12'hFFF, 3'b110}));

`ifdef TEXT_BLINK_EN
        // Cursor cell (3,2) toggles every 2 frames; neighbours stay normal
        for (int k = 0; k < 6; k++) begin
            add(10'd0,  10'd0,  16'h0000, 3'b001, 12'h000);
            add(10'd0,  10'd0,  16'h0000, 3'b000, 12'h000);
            add(10'd24, 10'd32, 16'h0010, 3'b100, BLINK_PH[k] ? 12'hFFF : 12'h000);
            add(10'd31, 10'd47, 16'h0010, 3'b100, BLINK_PH[k] ? 12'hFFF : 12'h000);
            add(10'd40, 10'd32, 16'h0010, 3'b100, 12'h000);
            add(10'd24, 10'd48, 16'h0010, 3'b100, 12'h000);
        end
        run_table("blink");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
